// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA sequencer and its environment
// (CPU register strobe, system-bus read port, PPU OAM write port).
interface oam_dma_if;
  logic        reg_write;
  logic [7:0]  d_wr;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_gnt;
  logic [7:0]  bus_d_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d;
  logic        oam_write;
  logic        oam_lock;
  logic        busy;

  // master: the DMA sequencer itself (it is the bus requester)
  modport master (
    input  reg_write, d_wr, bus_gnt, bus_d_rd,
    output bus_req, bus_addr, oam_addr, oam_d, oam_write, oam_lock, busy
  );

  modport slave (
    output reg_write, d_wr, bus_gnt, bus_d_rd,
    input  bus_req, bus_addr, oam_addr, oam_d, oam_write, oam_lock, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies NUM_BYTES bytes from page {page,8'h00} of the
// system bus into OAM, one bus read followed by one OAM write per byte.
//
// state | meaning
// IDLE  | no transfer in flight
// DELAY | counting START_DELAY cycles before the first bus request
// READ  | bus_req asserted for {page, idx}, waiting for bus_gnt
// WRITE | writing the latched byte to OAM[idx]
module oam_dma_ctrl #(
  parameter int NUM_BYTES   = 160,
  parameter int START_DELAY = 1
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);

  localparam int         DW   = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [7:0] LAST = 8'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      page_q, page_d;
  logic [7:0]      dbuf_q, dbuf_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            lock_q, lock_d;

  // Pages E0..FF are the CPU echo-RAM mirror of C0..DF.
  function automatic logic [7:0] unecho(input logic [7:0] p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= 8'h00;
      page_q  <= 8'h00;
      dbuf_q  <= 8'h00;
      dcnt_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      dbuf_q  <= dbuf_d;
      dcnt_q  <= dcnt_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    dbuf_d  = dbuf_q;
    dcnt_d  = dcnt_q;
    lock_d  = lock_q;

    // A register write starts or restarts from any state; lock is left as-is
    // so a restart mid-copy keeps the CPU locked out of OAM.
    if (bus.reg_write) begin
      page_d = unecho(bus.d_wr);
      idx_d  = 8'h00;
      dcnt_d = DW'(START_DELAY);
      if (START_DELAY == 0) begin
        state_d = S_READ;
        lock_d  = 1'b1;
      end else begin
        state_d = S_DELAY;
      end
    end else begin
      case (state_q)
        S_IDLE: ;
        S_DELAY: begin
          dcnt_d = dcnt_q - DW'(1);
          if (dcnt_q == DW'(1)) begin
            state_d = S_READ;
            lock_d  = 1'b1;
          end
        end
        S_READ: begin
          if (bus.bus_gnt) begin
            dbuf_d  = bus.bus_d_rd;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            lock_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = (state_q == S_READ);
  assign bus.bus_addr  = (state_q == S_READ) ? {page_q, idx_q} : 16'h0000;
  assign bus.oam_write = (state_q == S_WRITE);
  assign bus.oam_addr  = (state_q == S_WRITE) ? idx_q : 8'h00;
  assign bus.oam_d     = (state_q == S_WRITE) ? dbuf_q : 8'h00;
  assign bus.oam_lock  = lock_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: bus/arbiter model plus read and OAM-write
// scoreboards filled when each transfer is started.
module tb_oam_dma_ctrl;
  localparam int N  = 160;
  localparam int SD = 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   gnt_wait = 0;
  int   wcnt = 0;
  logic [15:0] cur_rd = 16'h0;
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  oam_dma_if bus();

  oam_dma_ctrl #(.NUM_BYTES(N), .START_DELAY(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.bus_d_rd = bus.bus_addr[7:0] ^ 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] echo_pg(input logic [7:0] p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

  task automatic push_xfer(input logic [7:0] page, input int nrd, input int nwr);
    for (int i = 0; i < nrd; i++) exp_rd.push_back({echo_pg(page), 8'(i)});
    for (int i = 0; i < nwr; i++) exp_wr.push_back({8'(i), 8'(i) ^ 8'h5A});
  endtask

  // Arbiter + scoreboard side; grants after gnt_wait cycles of waiting
  always @(negedge clk) begin
    if (bus.bus_req) begin
      if (wcnt == 0) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'(bus.bus_addr), 32'hFFFF_FFFF);
        else begin
          cur_rd = exp_rd.pop_front();
          chk("rd_addr", 32'(bus.bus_addr), 32'(cur_rd));
        end
      end else begin
        chk("rd_hold", 32'(bus.bus_addr), 32'(cur_rd));
      end
      bus.bus_gnt = (wcnt == gnt_wait);
      wcnt++;
    end else begin
      wcnt = 0;
      bus.bus_gnt = 1'b0;
    end
    if (bus.oam_write) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 32'({bus.oam_addr, bus.oam_d}), 32'hFFFF_FFFF);
      else chk("oam_wr", 32'({bus.oam_addr, bus.oam_d}), 32'(exp_wr.pop_front()));
    end
  end

  // Called at a negedge: strobes reg_write and times the transfer.
  task automatic measure(input logic [7:0] page, input logic lock_pre, input int budget,
                         output int t_req, output int t_wr, output int t_idle);
    int cyc = 0;
    t_req = -1; t_wr = -1; t_idle = -1;
    bus.reg_write = 1'b1;
    bus.d_wr = page;
    while (t_idle < 0) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
      cyc++;
      if (bus.bus_req && t_req < 0) t_req = cyc;
      if (bus.oam_write) t_wr = cyc;
      if (bus.busy) chk("lock_busy", 32'(bus.oam_lock), (t_req >= 0) ? 32'd1 : 32'(lock_pre));
      else begin
        t_idle = cyc;
        chk("lock_idle", 32'(bus.oam_lock), 32'd0);
      end
      if (cyc >= budget && t_idle < 0) begin
        chk("timeout", 32'(cyc), 32'(budget + 1));
        t_idle = cyc;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   32'(bus.bus_req),   32'd0);
    chk({tag, "_baddr"}, 32'(bus.bus_addr),  32'd0);
    chk({tag, "_oaddr"}, 32'(bus.oam_addr),  32'd0);
    chk({tag, "_od"},    32'(bus.oam_d),     32'd0);
    chk({tag, "_owr"},   32'(bus.oam_write), 32'd0);
    chk({tag, "_lock"},  32'(bus.oam_lock),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  initial begin
    int t_req, t_wr, t_idle;
    logic [7:0] pages [2];
    bit found;
    pages[0] = 8'hFE;
    pages[1] = 8'hE0;

    rst = 1'b0;
    bus.reg_write = 1'b0;
    bus.d_wr = 8'h00;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // Functional + timing, grant always immediate
    push_xfer(8'hC1, N, N);
    measure(8'hC1, 1'b0, 2000, t_req, t_wr, t_idle);
    chk("t_first_req", 32'(t_req), 32'(SD + 1));
    chk("t_last_wr",   32'(t_wr),  32'(SD + 2 * N));
    chk("t_idle",      32'(t_idle), 32'(SD + 2 * N + 1));
    chk("func_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("func_wr_left", 32'(exp_wr.size()), 32'd0);

    // Echo mirror pages
    for (int p = 0; p < 2; p++) begin
      push_xfer(pages[p], N, N);
      measure(pages[p], 1'b0, 2000, t_req, t_wr, t_idle);
      chk("echo_last_wr", 32'(t_wr), 32'(SD + 2 * N));
      chk("echo_rd_left", 32'(exp_rd.size()), 32'd0);
    end

    // Arbitration: 5 wait cycles per request
    gnt_wait = 5;
    push_xfer(8'h12, N, N);
    measure(8'h12, 1'b0, 3000, t_req, t_wr, t_idle);
    chk("arb_first_req", 32'(t_req), 32'(SD + 1));
    chk("arb_last_wr",   32'(t_wr),  32'(SD + 7 * N));
    chk("arb_idle",      32'(t_idle), 32'(SD + 7 * N + 1));
    chk("arb_wr_left",   32'(exp_wr.size()), 32'd0);
    gnt_wait = 0;

    // Restart during the 50th write
    push_xfer(8'h80, 50, 50);
    push_xfer(8'h90, N, N);
    bus.reg_write = 1'b1;
    bus.d_wr = 8'h80;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
      if (bus.busy && bus.bus_req) chk("rs_lock_pre", 32'(bus.oam_lock), 32'd1);
      if (bus.oam_write && bus.oam_addr == 8'd49) found = 1'b1;
    end
    chk("rs_found", 32'(found), 32'd1);
    measure(8'h90, 1'b1, 2000, t_req, t_wr, t_idle);
    chk("rs_first_req", 32'(t_req), 32'(SD + 1));
    chk("rs_last_wr",   32'(t_wr),  32'(SD + 2 * N));
    chk("rs_rd_left",   32'(exp_rd.size()), 32'd0);
    chk("rs_wr_left",   32'(exp_wr.size()), 32'd0);

    // Reset while reading idx 37, with a colliding reg_write
    push_xfer(8'h33, 38, 37);
    bus.reg_write = 1'b1;
    bus.d_wr = 8'h33;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      bus.reg_write = 1'b0;
      if (bus.bus_req && bus.bus_addr[7:0] == 8'd37) found = 1'b1;
    end
    chk("rst_found", 32'(found), 32'd1);
    rst = 1'b0;
    bus.reg_write = 1'b1;
    bus.d_wr = 8'h55;
    @(negedge clk);
    chk_quiet("midrst");
    rst = 1'b1;
    bus.reg_write = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("rst_wr_left", 32'(exp_wr.size()), 32'd0);
    push_xfer(8'h44, N, N);
    measure(8'h44, 1'b0, 2000, t_req, t_wr, t_idle);
    chk("post_rst_last_wr", 32'(t_wr), 32'(SD + 2 * N));
    chk("post_rst_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("post_rst_wr_left", 32'(exp_wr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
